// File: rtl/led_sweep_checker.sv
// Monitor for a Knight Rider LED sweep: decodes the lit position and direction,
// flags illegal steps and stalls, and reports lock, position and step period.
module led_sweep_checker #(
  parameter  int WIDTH    = 8,
  parameter  int STEP_MAX = 50_000_000,
  localparam int PW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] led_in,
  input  logic             enable,
  input  logic             clear_err,
  output logic [PW-1:0]    pos,
  output logic             dir,
  output logic             locked,
  output logic             err_pulse,
  output logic [15:0]      err_count,
  output logic [31:0]      step_cycles,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {IDLE, ACQ, SYNC, TRACK} state_t;

  state_t           state;
  logic [WIDTH-1:0] r0, r1;
  logic [31:0]      gap;
  logic [31:0]      gap_inc;
  logic             change, onehot;
  logic [PW-1:0]    idx;
  logic [PW:0]      idx_x, pos_up, pos_dn;
  logic             adjacent, forward, timeout, dir_next;
  logic             accept, fault;

  assign fsm_state = state;

  assign change = (r0 != r1);
  assign onehot = $onehot(r0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r0[i]) idx = PW'(i);
    end
  end

  // One extra bit keeps pos-1 at pos=0 from aliasing onto a real index.
  assign idx_x    = {1'b0, idx};
  assign pos_up   = {1'b0, pos} + (PW+1)'(1);
  assign pos_dn   = {1'b0, pos} - (PW+1)'(1);
  assign adjacent = (idx_x == pos_up) || (idx_x == pos_dn);
  assign forward  = dir ? (idx_x == pos_up) : (idx_x == pos_dn);
  assign timeout  = (gap == 32'(STEP_MAX - 1));
  assign gap_inc  = (gap == 32'(STEP_MAX)) ? gap : gap + 32'd1;

  always_comb begin
    if (idx == PW'(WIDTH - 1))
      dir_next = 1'b0;
    else if (idx == '0)
      dir_next = 1'b1;
    else
      dir_next = (idx > pos);
  end

  always_comb begin
    accept = 1'b0;
    fault  = 1'b0;
    if (enable && (state == SYNC || state == TRACK)) begin
      if (change) begin
        if (onehot && ((state == SYNC) ? adjacent : forward))
          accept = 1'b1;
        else
          fault = 1'b1;
      end else if (timeout) begin
        fault = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      r0          <= '0;
      r1          <= '0;
      gap         <= '0;
      pos         <= '0;
      dir         <= 1'b1;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      step_cycles <= '0;
    end else begin
      r0        <= led_in;
      r1        <= r0;
      err_pulse <= fault;

      // An error landing on a clear leaves exactly that one error counted.
      if (fault)
        err_count <= clear_err ? 16'd1 :
                     (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
      else if (clear_err)
        err_count <= '0;

      if (accept) begin
        pos         <= idx;
        dir         <= dir_next;
        step_cycles <= gap + 32'd1;
      end

      if (!enable) begin
        state  <= IDLE;
        locked <= 1'b0;
        gap    <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= ACQ;
            gap   <= '0;
          end
          ACQ: begin
            if (onehot) begin
              pos   <= idx;
              state <= SYNC;
              gap   <= '0;
            end else begin
              gap <= gap_inc;
            end
          end
          default: begin
            if (fault) begin
              state  <= ACQ;
              locked <= 1'b0;
              gap    <= '0;
            end else if (accept) begin
              state  <= TRACK;
              locked <= 1'b1;
              gap    <= '0;
            end else begin
              gap <= gap_inc;
            end
          end
        endcase
      end
    end
  end

endmodule
